dem_level_decoder: RTL

Receive-side counterpart to the quantizer/DEM switch-block path. Takes the unit-element selection vector driven onto the DAC elements, reconstructs the quantized level by counting selected elements, and flags any mismatch against the delayed quantizer code. It also keeps saturating per-element usage counters and runs an on-demand scan reporting usage spread (max − min). It sits beside the DAC element array as a monitor and self-check block.

---
 rtl/lib_switchblock_pkg.sv | 16 +
 rtl/dem_popcount.sv | 18 +
 rtl/dem_level_decoder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/lib_switchblock_pkg.sv
// Shared definitions for the switch-block / quantizer / DEM monitor path.
package lib_switchblock_pkg;

  // Defaults shared with the switch block and quantizer (MAX_LEVEL == element count)
  localparam int DEFAULT_NUM_ELEMENTS = 8;
  localparam int DEFAULT_OUTPUT_WIDTH = 4;
  localparam int DEFAULT_CNT_WIDTH    = 16;

  // Usage-spread scan sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/dem_popcount.sv
// Combinational population count of a W-bit vector.
module dem_popcount #(
  parameter int W     = 4,
  parameter int OUT_W = 3
) (
  input  logic [W-1:0]     vec,
  output logic [OUT_W-1:0] count
);

  // Sum every bit of the vector; OUT_W must be wide enough to hold W
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + OUT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/dem_level_decoder.sv
// DEM level decoder: rebuilds the quantizer level from the unit-element
// selection vector, flags disagreement with the reference level, and keeps
// per-element usage counters with an on-demand max-min spread scan.
module dem_level_decoder
  import lib_switchblock_pkg::*;
#(
  parameter int NUM_ELEMENTS = DEFAULT_NUM_ELEMENTS,
  parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH,
  parameter int CNT_WIDTH    = DEFAULT_CNT_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  input  logic [NUM_ELEMENTS-1:0] elem_sel_i,
  input  logic [OUTPUT_WIDTH-1:0] ref_level_i,
  output logic [OUTPUT_WIDTH-1:0] level_o,
  output logic                    valid_o,
  output logic                    mismatch_o,
  input  logic                    clear_i,
  input  logic                    scan_start_i,
  output logic                    scan_done_o,
  output logic [CNT_WIDTH-1:0]    spread_o
);

  localparam int LO_W  = NUM_ELEMENTS / 2;
  localparam int HI_W  = NUM_ELEMENTS - LO_W;
  localparam int IDX_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;

  localparam logic [OUTPUT_WIDTH-1:0] MAX_LEVEL = OUTPUT_WIDTH'(NUM_ELEMENTS);
  localparam logic [CNT_WIDTH-1:0]    CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]    CNT_MAX   = '1;
  localparam logic [IDX_W-1:0]        IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(NUM_ELEMENTS - 1);

  // Half-vector popcounts keep the adder chain short ahead of the S1 register
  logic [OUTPUT_WIDTH-1:0] lo_cnt, hi_cnt;

  dem_popcount #(.W(LO_W), .OUT_W(OUTPUT_WIDTH)) u_pop_lo (
    .vec   (elem_sel_i[LO_W-1:0]),
    .count (lo_cnt)
  );

  dem_popcount #(.W(HI_W), .OUT_W(OUTPUT_WIDTH)) u_pop_hi (
    .vec   (elem_sel_i[NUM_ELEMENTS-1:LO_W]),
    .count (hi_cnt)
  );

  logic                    valid_q;
  logic [OUTPUT_WIDTH-1:0] ref_q, lo_cnt_q, hi_cnt_q, level_sum;

  // Stage 1: capture the reference level and both half counts
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      ref_q    <= '0;
      lo_cnt_q <= '0;
      hi_cnt_q <= '0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        ref_q    <= ref_level_i;
        lo_cnt_q <= lo_cnt;
        hi_cnt_q <= hi_cnt;
      end
    end
  end

  // The sum cannot exceed NUM_ELEMENTS, so it never overflows OUTPUT_WIDTH
  assign level_sum = lo_cnt_q + hi_cnt_q;

  // Stage 2: publish the level and mismatch flag, holding them on idle cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o    <= 1'b0;
      level_o    <= '0;
      mismatch_o <= 1'b0;
    end else begin
      valid_o <= valid_q;
      if (valid_q) begin
        level_o    <= level_sum;
        mismatch_o <= (level_sum != ref_q) || (ref_q > MAX_LEVEL);
      end
    end
  end

  logic [CNT_WIDTH-1:0] usage_q [NUM_ELEMENTS];

  // Saturating per-element usage counters; clear beats a same-cycle increment
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_ELEMENTS; k++) usage_q[k] <= '0;
    end else if (clear_i) begin
      for (int k = 0; k < NUM_ELEMENTS; k++) usage_q[k] <= '0;
    end else if (valid_i) begin
      for (int k = 0; k < NUM_ELEMENTS; k++) begin
        if (elem_sel_i[k] && (usage_q[k] != CNT_MAX)) begin
          usage_q[k] <= usage_q[k] + CNT_ONE;
        end
      end
    end
  end

  scan_state_t          scan_state;
  logic [IDX_W-1:0]     scan_idx;
  logic [CNT_WIDTH-1:0] scan_min, scan_max, scan_sample, scan_min_nxt, scan_max_nxt;

  assign scan_sample  = usage_q[scan_idx];
  assign scan_min_nxt = (scan_sample < scan_min) ? scan_sample : scan_min;
  assign scan_max_nxt = (scan_sample > scan_max) ? scan_sample : scan_max;

  // Scan sequencer: walk one counter per cycle, then pulse done with max-min
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scan_state  <= IDLE;
      scan_idx    <= '0;
      scan_min    <= '0;
      scan_max    <= '0;
      spread_o    <= '0;
      scan_done_o <= 1'b0;
    end else begin
      scan_done_o <= 1'b0;
      case (scan_state)
        IDLE: begin
          if (scan_start_i && !clear_i) begin
            scan_state <= SCAN;
            scan_idx   <= '0;
            scan_min   <= '1;
            scan_max   <= '0;
          end
        end
        SCAN: begin
          if (clear_i) begin
            scan_state <= IDLE;
          end else begin
            scan_min <= scan_min_nxt;
            scan_max <= scan_max_nxt;
            scan_idx <= scan_idx + IDX_ONE;
            if (scan_idx == LAST_IDX) begin
              scan_state  <= DONE;
              scan_done_o <= 1'b1;
              spread_o    <= scan_max_nxt - scan_min_nxt;
            end
          end
        end
        DONE: begin
          scan_state <= IDLE;
        end
        default: begin
          scan_state <= IDLE;
        end
      endcase
    end
  end

endmodule
